// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART receive definitions: FSM states and default frame/tick parameters.
package uart_rx_ctrl_pkg;

  localparam int unsigned DATA_BITS_DEF    = 8;
  localparam int unsigned SAMPLE_POINT_DEF = 7;
  localparam int unsigned PROG_W_DEF       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  function automatic int unsigned cnt_width(input int unsigned bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_sync2.sv
// Two-flop synchronizer for the raw serial line; resets to the idle (high) level.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive framing controller: start detection, bsc enable, mid-bit sampling,
// LSB-first assembly and single-cycle char_ready / frame_err strobes.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF,
  parameter int unsigned SAMPLE_POINT = SAMPLE_POINT_DEF,
  parameter int unsigned PROG_W       = PROG_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic [PROG_W-1:0]    bitProgress,
  output logic                 bsc_enable,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 char_ready,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int unsigned CNT_W = cnt_width(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 rx_s;
  logic                 rx_prev;
  logic                 smp;
  logic [DATA_BITS-1:0] shreg;
  logic [CNT_W-1:0]     bit_cnt;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  assign smp = bsc_enable & (bitProgress == PROG_W'(SAMPLE_POINT));

  // rx_busy is registered alongside state so it tracks state != IDLE exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rx_prev    <= 1'b1;
      bsc_enable <= 1'b0;
      data_out   <= '0;
      char_ready <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
    end else begin
      rx_prev    <= rx_s;
      char_ready <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state      <= START;
            bsc_enable <= 1'b1;
            rx_busy    <= 1'b1;
          end
        end
        START: begin
          if (smp) begin
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state      <= IDLE;
              bsc_enable <= 1'b0;
              rx_busy    <= 1'b0;
            end
          end
        end
        DATA: begin
          if (smp) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) state <= STOP;
          end
        end
        STOP: begin
          // Leave mid-stop-bit so the next start edge is caught immediately.
          if (smp) begin
            if (rx_s) begin
              data_out   <= shreg;
              char_ready <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
            state      <= IDLE;
            bsc_enable <= 1'b0;
            rx_busy    <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          bsc_enable <= 1'b0;
          rx_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural 16x bit-tick counter standing in for bsc.
module tb_uart_rx_ctrl;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [3:0] prog;
  logic       bsc_enable;
  logic [7:0] data_out;
  logic       char_ready;
  logic       frame_err;
  logic       rx_busy;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0, last_smp = 0;
  int cr_pulses = 0, cr_hi = 0, fe_pulses = 0, fe_hi = 0, both_hi = 0;
  int busy_cnt = 0, en_cnt = 0, cr_lat = -1;
  logic [7:0] cr_data = '0, cr_data_prev = '0;
  logic cr_prev = 1'b0, fe_prev = 1'b0;

  int s_cr, s_crhi, s_fe, s_fehi, s_both, s_busy, s_en;

  uart_rx_ctrl #(
    .DATA_BITS    (8),
    .SAMPLE_POINT (7),
    .PROG_W       (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .bitProgress (prog),
    .bsc_enable  (bsc_enable),
    .data_out    (data_out),
    .char_ready  (char_ready),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             prog <= '0;
    else if (!bsc_enable) prog <= '0;
    else                  prog <= prog + 4'd1;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bsc_enable && prog == 4'd7) last_smp = cyc;
    if (char_ready) begin
      cr_hi = cr_hi + 1;
      if (!cr_prev) begin
        cr_pulses    = cr_pulses + 1;
        cr_lat       = cyc - last_smp;
        cr_data_prev = cr_data;
        cr_data      = data_out;
      end
    end
    if (frame_err) begin
      fe_hi = fe_hi + 1;
      if (!fe_prev) fe_pulses = fe_pulses + 1;
    end
    if (char_ready && frame_err) both_hi = both_hi + 1;
    busy_cnt = busy_cnt + int'(rx_busy);
    en_cnt   = en_cnt + int'(bsc_enable);
    cr_prev  = char_ready;
    fe_prev  = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_cr = cr_pulses; s_crhi = cr_hi; s_fe = fe_pulses; s_fehi = fe_hi;
    s_both = both_hi; s_busy = busy_cnt; s_en = en_cnt;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_in = 1'b1;
    end
  endtask

  // Drives the first ncyc clocks of a 160-clock frame, changing rx_in off ns after each edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned off,
                            input int unsigned ncyc);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int unsigned c = 0; c < ncyc; c++) begin
      @(posedge clk); #(off);
      rx_in = f[c / 16];
    end
  endtask

  task automatic check_good(input string tag, input logic [7:0] exp);
    check({tag, "_cr_pulses"}, cr_pulses - s_cr, 1);
    check({tag, "_cr_width"},  cr_hi - s_crhi, 1);
    check({tag, "_fe_pulses"}, fe_pulses - s_fe, 0);
    check({tag, "_data_out"},  data_out, {24'd0, exp});
    check({tag, "_strobe_data"}, cr_data, {24'd0, exp});
    check({tag, "_latency"},   cr_lat, 1);
    check({tag, "_busy_after"}, rx_busy, 0);
  endtask

  initial begin
    rst   = 1'b0;
    rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bsc_enable", bsc_enable, 0);
    check("rst_data_out",   data_out, 0);
    check("rst_char_ready", char_ready, 0);
    check("rst_frame_err",  frame_err, 0);
    check("rst_rx_busy",    rx_busy, 0);
    rst = 1'b1;
    idle(10);

    // 1: good frame 0xA5
    snap();
    send_frame(8'hA5, 1'b1, 1, 160);
    idle(20);
    check_good("t1", 8'hA5);
    check("t1_busy_cycles", busy_cnt - s_busy, 152);
    check("t1_en_cycles",   en_cnt - s_en, 152);

    // 2: start glitch of 4 clocks
    snap();
    @(posedge clk); #1; rx_in = 1'b0;
    repeat (4) @(posedge clk);
    #1; rx_in = 1'b1;
    idle(40);
    check("t2_busy_cycles", busy_cnt - s_busy, 8);
    check("t2_en_cycles",   en_cnt - s_en, 8);
    check("t2_bsc_enable",  bsc_enable, 0);
    check("t2_cr_pulses",   cr_pulses - s_cr, 0);
    check("t2_fe_pulses",   fe_pulses - s_fe, 0);
    check("t2_data_out",    data_out, 32'hA5);

    // 3: 0x3C with stop bit 0
    snap();
    send_frame(8'h3C, 1'b0, 1, 160);
    idle(30);
    check("t3_fe_pulses", fe_pulses - s_fe, 1);
    check("t3_fe_width",  fe_hi - s_fehi, 1);
    check("t3_cr_pulses", cr_pulses - s_cr, 0);
    check("t3_data_out",  data_out, 32'hA5);
    check("t3_busy_after", rx_busy, 0);

    // 4: back-to-back 0x00 then 0xFF
    snap();
    send_frame(8'h00, 1'b1, 1, 160);
    send_frame(8'hFF, 1'b1, 1, 160);
    idle(20);
    check("t4_cr_pulses", cr_pulses - s_cr, 2);
    check("t4_cr_width",  cr_hi - s_crhi, 2);
    check("t4_first",     cr_data_prev, 32'h00);
    check("t4_second",    cr_data, 32'hFF);
    check("t4_data_out",  data_out, 32'hFF);
    check("t4_fe_pulses", fe_pulses - s_fe, 0);

    // 5: reset during 4th data bit of 0x5A, then 0x81
    send_frame(8'h5A, 1'b1, 1, 72);
    check("t5_busy_before", rx_busy, 1);
    #3; rst = 1'b0;
    #1;
    check("t5_rst_bsc_enable", bsc_enable, 0);
    check("t5_rst_data_out",   data_out, 0);
    check("t5_rst_char_ready", char_ready, 0);
    check("t5_rst_frame_err",  frame_err, 0);
    check("t5_rst_rx_busy",    rx_busy, 0);
    rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    idle(40);
    snap();
    send_frame(8'h81, 1'b1, 1, 160);
    idle(20);
    check_good("t5", 8'h81);

    // 6: line changes 2 ns before the sampling edge
    snap();
    send_frame(8'hC3, 1'b1, 8, 160);
    idle(20);
    check_good("t6", 8'hC3);
    check("t6_busy_cycles", busy_cnt - s_busy, 152);

    check("strobes_never_both", both_hi, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
